// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: request/response and RTC pad signals of the RTC bus stage
interface rtc_bus_ctrl_if;
  logic       req;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       cs_n;
  logic       ad_n;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  modport master (
    output req, rw, addr, wdata, ad_in,
    input  busy, done, rdata, cs_n, ad_n, wr_n, rd_n, ad_out, ad_oe
  );
  modport slave (
    input  req, rw, addr, wdata, ad_in,
    output busy, done, rdata, cs_n, ad_n, wr_n, rd_n, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: turns one register request into a timed multiplexed A/D bus cycle
module rtc_bus_ctrl #(
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_PULSE = 10,
  parameter int unsigned T_HOLD  = 4
) (
  input logic           clk,
  input logic           reset,
  rtc_bus_ctrl_if.slave bus
);
  // counter reload values; a zero-length phase still lasts one cycle
  localparam logic [7:0] LD_SETUP = T_SETUP == 0 ? 8'd0 : 8'(T_SETUP - 1);
  localparam logic [7:0] LD_PULSE = T_PULSE == 0 ? 8'd0 : 8'(T_PULSE - 1);
  localparam logic [7:0] LD_HOLD  = T_HOLD  == 0 ? 8'd0 : 8'(T_HOLD  - 1);
  typedef enum logic [2:0] {
    IDLE, ADDR_SETUP, ADDR_STRB, ADDR_HOLD, DATA_SETUP, DATA_STRB, DATA_HOLD, DONE
  } state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, addr_q, addr_d, wdata_q, wdata_d, rdata_q, ad_out_q, ad_out_d;
  logic       rw_q, rw_d, busy_q, done_q, cs_n_q, ad_n_q, wr_n_q, rd_n_q, ad_oe_q;
  logic       accept, last, a_ph, d_ph;
  always_comb begin
    accept   = state_q == IDLE && bus.req;
    last     = cnt_q == 8'd0;
    state_d  = accept ? ADDR_SETUP :
               state_q == DONE ? IDLE :
               state_q != IDLE && last ? state_t'(state_q + 3'd1) : state_q;
    cnt_d    = state_d == state_q ? (last ? 8'd0 : cnt_q - 8'd1) :
               state_d inside {ADDR_SETUP, DATA_SETUP} ? LD_SETUP :
               state_d inside {ADDR_STRB, DATA_STRB} ? LD_PULSE :
               state_d inside {ADDR_HOLD, DATA_HOLD} ? LD_HOLD : 8'd0;
    rw_d     = accept ? bus.rw : rw_q;
    addr_d   = accept ? bus.addr : addr_q;
    wdata_d  = accept ? bus.wdata : wdata_q;
    a_ph     = state_d inside {ADDR_SETUP, ADDR_STRB, ADDR_HOLD};
    d_ph     = state_d inside {DATA_SETUP, DATA_STRB, DATA_HOLD};
    ad_out_d = a_ph ? addr_d : d_ph ? wdata_d : 8'h00;
  end
  // outputs are registered from the next state so pins change with the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      rw_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= state_d != IDLE;
      done_q   <= state_d == DONE;
      cs_n_q   <= !(a_ph || d_ph);
      ad_n_q   <= !a_ph;
      wr_n_q   <= !(state_d == ADDR_STRB || (state_d == DATA_STRB && !rw_d));
      rd_n_q   <= !(state_d == DATA_STRB && rw_d);
      ad_oe_q  <= a_ph || (d_ph && !rw_d);
      ad_out_q <= ad_out_d;
      if (state_q == DATA_STRB && last && rw_q) rdata_q <= bus.ad_in;
    end
  end
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;
  assign bus.cs_n   = cs_n_q;
  assign bus.ad_n   = ad_n_q;
  assign bus.wr_n   = wr_n_q;
  assign bus.rd_n   = rd_n_q;
  assign bus.ad_out = ad_out_q;
  assign bus.ad_oe  = ad_oe_q;
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: randomized scoreboard bench for rtc_bus_ctrl
module tb_rtc_bus_ctrl;
  localparam int TS = 4, TP = 10, TH = 4;
  localparam int L  = 2 * (TS + TP + TH);
  localparam int L2 = 2 * (1 + 1 + 1);
  typedef struct {
    int unsigned at;
    bit          rw;
    logic [7:0]  a, w, din, rd;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  int unsigned cyc = 0;
  int tests = 0, fails = 0;
  int unsigned next_free = 0;
  logic [7:0] model_rdata = 8'h00;
  exp_t sb[$];
  int a_len = 0, d_len = 0, r_len = 0;
  logic [8:0] cap_a = '0, cap_w = '0;
  logic prev_adn = 1;
  rtc_bus_ctrl_if bus ();
  rtc_bus_ctrl_if b2 ();
  rtc_bus_ctrl u_dut (.clk(clk), .reset(reset), .bus(bus));
  rtc_bus_ctrl #(.T_SETUP(0), .T_PULSE(1), .T_HOLD(1)) u_fast (.clk(clk), .reset(reset), .bus(b2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic issue(input bit r, input logic [7:0] a, input logic [7:0] w, input logic [7:0] d, input bit keep);
    int unsigned acc;
    @(negedge clk);
    bus.req = 1; bus.rw = r; bus.addr = a; bus.wdata = w;
    acc = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    next_free = acc + L + 2;
    if (r) model_rdata = d;
    sb.push_back('{acc + L, r, a, w, d, model_rdata});
    while (cyc < acc) @(negedge clk);
    if (!keep) bus.req = 0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("strobe_excl", 32'(!bus.wr_n && !bus.rd_n), 0);
        chk("oe_during_rd", 32'(bus.ad_oe && !bus.rd_n), 0);
        if (bus.ad_n != prev_adn) chk("adn_under_strobe", 32'(!bus.wr_n || !bus.rd_n), 0);
        if (!bus.cs_n && !bus.ad_n && !bus.wr_n) begin a_len++; cap_a = {bus.ad_oe, bus.ad_out}; end
        if (!bus.cs_n && bus.ad_n && !bus.wr_n) begin d_len++; cap_w = {bus.ad_oe, bus.ad_out}; end
        if (!bus.rd_n) begin r_len++; chk("rd_in_data_phase", 32'(bus.ad_n), 1); end
        if (bus.done) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL spurious_done at cycle %0d: got done=1 expected no transaction", cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", cyc, e.at);
            chk("rdata", 32'(bus.rdata), 32'(e.rd));
            chk("busy_in_done", 32'(bus.busy), 1);
            chk("addr_on_bus", 32'(cap_a), 32'({1'b1, e.a}));
            chk("addr_strobe_len", a_len, TP);
            chk("data_wr_len", d_len, e.rw ? 0 : TP);
            chk("data_rd_len", r_len, e.rw ? TP : 0);
            if (!e.rw) chk("wdata_on_bus", 32'(cap_w), 32'({1'b1, e.w}));
          end
          a_len = 0; d_len = 0; r_len = 0; cap_a = '0; cap_w = '0;
        end
      end
      prev_adn = bus.ad_n;
      bus.ad_in = sb.size() != 0 ? sb[0].din : 8'h00;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, k, first, cnt;
    bus.req = 0; bus.rw = 0; bus.addr = 0; bus.wdata = 0;
    b2.req = 0; b2.rw = 0; b2.addr = 0; b2.wdata = 0; b2.ad_in = 0;
    repeat (2) @(negedge clk);
    chk("rst_cs_n", 32'(bus.cs_n), 1);
    chk("rst_ad_n", 32'(bus.ad_n), 1);
    chk("rst_wr_n", 32'(bus.wr_n), 1);
    chk("rst_rd_n", 32'(bus.rd_n), 1);
    chk("rst_ad_oe", 32'(bus.ad_oe), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_ad_out", 32'(bus.ad_out), 0);
    reset = 1;
    next_free = cyc + 1;
    issue(0, 8'h21, 8'h45, 8'h00, 0);
    issue(1, 8'h22, 8'h00, 8'h17, 0);
    issue(0, 8'h5c, 8'h9e, 8'h00, 0);
    // stray request for 0x33 while the 0x21 write is in flight
    issue(0, 8'h21, 8'h66, 8'h00, 0);
    repeat (5) @(negedge clk);
    bus.req = 1; bus.addr = 8'h33; bus.wdata = 8'hcc;
    repeat (2) @(negedge clk);
    bus.req = 0;
    issue(1, 8'h40, 8'h00, 8'ha5, 0);
    n = 0;
    while (bus.rd_n && n < 100) begin @(negedge clk); n++; end
    if (bus.rd_n) begin
      tests++; fails++;
      $display("FAIL rd_strobe_wait: got rd_n=1 expected 0 within 100 cycles");
    end
    #2 reset = 0;
    #1;
    chk("arst_cs_n", 32'(bus.cs_n), 1);
    chk("arst_rd_n", 32'(bus.rd_n), 1);
    chk("arst_ad_oe", 32'(bus.ad_oe), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_rdata", 32'(bus.rdata), 0);
    sb.delete();
    model_rdata = 8'h00;
    a_len = 0; d_len = 0; r_len = 0; cap_a = '0; cap_w = '0;
    @(negedge clk);
    reset = 1;
    next_free = cyc + 1;
    issue(0, 8'h12, 8'h34, 8'h00, 0);
    for (int i = 0; i < 4; i++)
      issue(1'(i), 8'(8'h70 + i), 8'(8'h80 + i), 8'(8'h90 + i), 1);
    @(negedge clk);
    bus.req = 0;
    for (int i = 0; i < 12; i++) begin
      bit keep;
      keep = $urandom_range(0, 3) == 0;
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    bus.req = 0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
    b2.req = 1; b2.rw = 1; b2.addr = 8'h0f; b2.ad_in = 8'h5a;
    k = cyc + 1;
    @(negedge clk);
    b2.req = 0;
    first = -1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      chk("fast_strobe_excl", 32'(!b2.wr_n && !b2.rd_n), 0);
      chk("fast_oe_during_rd", 32'(b2.ad_oe && !b2.rd_n), 0);
      if (b2.done) begin cnt++; if (first < 0) first = int'(cyc); end
      @(negedge clk);
    end
    chk("fast_done_cycle", first, k + L2);
    chk("fast_done_count", cnt, 1);
    chk("fast_rdata", 32'(b2.rdata), 32'h5a);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
